// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the ID-stage control logic and the hazard/stall unit.
// The master drives the pipeline-state fields and receives the stall/flush controls.
interface hazard_stall_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           rsID;
  logic [4:0]           rtID;
  logic                 useRsID;
  logic                 useRtID;
  logic                 branchID;
  logic                 mduOpID;
  logic                 mduReadID;
  logic                 branchTakenID;
  logic [4:0]           destRegEX;
  logic                 regWriteEX;
  logic                 memReadEX;
  logic [4:0]           destRegMEM;
  logic                 memReadMEM;
  logic                 mduStartEX;
  logic                 stallIF;
  logic                 stallID;
  logic                 flushEX;
  logic                 flushID;
  logic                 mduBusy;
  logic [CNT_WIDTH-1:0] stallCount;

  modport master (
    output rsID, rtID, useRsID, useRtID, branchID, mduOpID, mduReadID,
           branchTakenID, destRegEX, regWriteEX, memReadEX, destRegMEM,
           memReadMEM, mduStartEX,
    input  stallIF, stallID, flushEX, flushID, mduBusy, stallCount
  );

  modport slave (
    input  rsID, rtID, useRsID, useRtID, branchID, mduOpID, mduReadID,
           branchTakenID, destRegEX, regWriteEX, memReadEX, destRegMEM,
           memReadMEM, mduStartEX,
    output stallIF, stallID, flushEX, flushID, mduBusy, stallCount
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush generator for hazards that bypassing cannot cover: load-use, ID-stage
// branch operands, multi-cycle MDU busy, and taken-branch squash of the fetch slot.
module hazard_stall_unit #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_WIDTH   = 16
) (
    input logic                 Clock,
    input logic                 Reset,
    hazard_stall_unit_if.slave  hz
);

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    localparam logic [5:0] RELOAD = 6'(MDU_LATENCY - 1);

    mdu_state_t           state;
    logic [5:0]           cnt;
    logic                 busy;
    logic [CNT_WIDTH-1:0] stall_count;

    logic match_ex, match_mem;
    logic load_use, br_ex, br_mem, mdu_haz, stall;

    // Register 0 is hardwired, so a zero destination never conflicts.
    assign match_ex  = hz.regWriteEX && (hz.destRegEX != 5'd0) &&
                       ((hz.useRsID && (hz.rsID == hz.destRegEX)) ||
                        (hz.useRtID && (hz.rtID == hz.destRegEX)));
    assign match_mem = (hz.destRegMEM != 5'd0) &&
                       ((hz.useRsID && (hz.rsID == hz.destRegMEM)) ||
                        (hz.useRtID && (hz.rtID == hz.destRegMEM)));

    assign load_use = hz.memReadEX && match_ex;
    assign br_ex    = hz.branchID && match_ex;
    assign br_mem   = hz.branchID && hz.memReadMEM && match_mem;
    assign mdu_haz  = busy && (hz.mduOpID || hz.mduReadID);
    assign stall    = load_use || br_ex || br_mem || mdu_haz;

    // A stalled branch is re-evaluated next cycle, so it must not squash now.
    assign hz.stallIF    = stall && !Reset;
    assign hz.stallID    = stall && !Reset;
    assign hz.flushEX    = stall && !Reset;
    assign hz.flushID    = hz.branchTakenID && !stall && !Reset;
    assign hz.mduBusy    = busy;
    assign hz.stallCount = stall_count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.mduStartEX) begin
                        state <= BUSY;
                        cnt   <= RELOAD;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (hz.mduStartEX) begin
                        cnt <= RELOAD;
                    end else if (cnt == 6'd1) begin
                        state <= IDLE;
                        cnt   <= 6'd0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
            endcase
        end
    end

    // Saturating so a long stall storm cannot wrap the statistic back to small values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline hazard detector for the 5-stage MIPS32 core. It is the stall/flush counterpart of forwardingUnit: it covers the hazards that bypassing cannot resolve. These are load-use, branch operands compared in ID, multi-cycle MULT/DIV busy, and control-flow squash. It sits beside ID and drives the PC, IF/ID and ID/EX pipeline-register enables and flushes. It also keeps an MDU busy state machine and a stall performance counter.

Parameters:
MDU_LATENCY, 32, cycles from MULT/DIV issue in EX until HI/LO valid; legal range 2..63
CNT_WIDTH, 16, width of the stall statistics counter

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
rsID  in  5  rs field of the instruction in ID
rtID  in  5  rt field of the instruction in ID
useRsID  in  1  ID instruction reads rs
useRtID  in  1  ID instruction reads rt
branchID  in  1  ID instruction is a branch that compares its operands in ID
mduOpID  in  1  ID instruction is MULT/MULTU/DIV/DIVU
mduReadID  in  1  ID instruction is MFHI/MFLO
branchTakenID  in  1  ID branch/jump resolved as taken
destRegEX  in  5  destination register of EX
regWriteEX  in  1  EX writes the register file
memReadEX  in  1  EX is a load
destRegMEM  in  5  destination register of MEM
memReadMEM  in  1  MEM is a load
mduStartEX  in  1  MULT/DIV enters EX this cycle (one-cycle pulse)
stallIF  out  1  hold PC
stallID  out  1  hold IF/ID
flushEX  out  1  insert a bubble into ID/EX
flushID  out  1  squash IF/ID (wrong-path fetch)
mduBusy  out  1  MDU result not yet valid
stallCount  out  CNT_WIDTH  number of stalled cycles since reset

Behaviour:
- Register 0 never creates a hazard. Every match term requires the destination register to be nonzero.
- matchEX = regWriteEX, destRegEX!=0, and (useRsID and rsID==destRegEX, or useRtID and rtID==destRegEX).
- matchMEM = same form as matchEX, using destRegMEM.
- Hazard terms:
  - loadUse = memReadEX and matchEX.
  - brEX = branchID and matchEX. The ALU result is not yet available for the ID comparator.
  - brMEM = branchID and memReadMEM and matchMEM.
  - mduHaz = mduBusy and (mduOpID or mduReadID).
  - stall = loadUse or brEX or brMEM or mduHaz.
- Stall outputs are combinational in the same cycle: stallIF = stallID = flushEX = stall.
- flushID = branchTakenID and not stall. When a stall and a taken branch coincide, the stall wins and flushID=0. The branch is re-evaluated on the next cycle.
- MDU state machine, with a 6-bit down-counter cnt:
  - IDLE: mduBusy=0. On mduStartEX, go to BUSY with cnt=MDU_LATENCY-1.
  - BUSY: mduBusy=1 and cnt decrements each cycle. When cnt==1 the next state is IDLE, so mduBusy stays high for exactly MDU_LATENCY-1 cycles after the issue cycle.
  - mduStartEX while BUSY reloads cnt=MDU_LATENCY-1. This is the back-to-back case the stall normally prevents; it is defined for robustness.
- mduBusy is registered and derived only from state.
- stallCount increments by 1 on each rising edge where stall=1 and Reset=0. It saturates at all-ones and never wraps.
- While Reset=1:
  - Combinational outputs stallIF, stallID, flushEX and flushID are forced to 0.
  - On the next edge: state=IDLE, cnt=0, mduBusy=0, stallCount=0.
  - A reset during BUSY abandons the operation immediately.
- Latency: 0 cycles from input to stall/flush outputs. 1 cycle from input to mduBusy and stallCount.
- Inputs are assumed stable before the clock edge. The block has no internal pipelining of hazard detection.

Test Plan:
1. Load-use. destRegEX=5, memReadEX=1, regWriteEX=1, rsID=5, useRsID=1 -> stallIF=stallID=flushEX=1. Next edge -> stallCount=1. Same stimulus with destRegEX=0 -> no stall.
2. Branch stalls.
   - branchID=1, rtID=7, useRtID=1, destRegEX=7, regWriteEX=1, memReadEX=0 -> stall=1.
   - Then memReadMEM=1, destRegMEM=7, regWriteEX=0 -> stall=1.
   - Then memReadMEM=0 -> stall=0.
3. MDU. With MDU_LATENCY=4, pulse mduStartEX at cycle 0 -> mduBusy=1 for cycles 1-3 and 0 at cycle 4. mduReadID=1 held throughout -> stall=1 in cycles 1-3, 0 at cycle 4.
4. Stall versus flush. loadUse active and branchTakenID=1 -> flushID=0, stall=1. Next cycle, hazard cleared and branchTakenID=1 -> flushID=1, stall=0.
5. Reset mid-operation. MDU in BUSY with cnt=2, assert Reset for one cycle -> mduBusy=0, stallCount=0, all stall/flush outputs 0 during reset. A later mduReadID causes no stall.
6. Saturation. CNT_WIDTH=4, hold loadUse for 20 cycles -> stallCount reaches 15 and stays 15.
